nanov_sequencer: RTL and testbench

Instruction sequencer and fetch controller for the bit-serial nanoV core. It owns the PC and fetches 32-bit instruction words over a req/valid memory handshake. It latches each word and drives the core's serial step counter (counter, 0..31) and per-instruction phase (cycle). It also applies branch results at instruction end and halts on EBREAK until resumed by a debug/host agent.

---
 rtl/nanov_pkg.sv | 28 ++
 rtl/nanov_sequencer_if.sv | 23 ++
 rtl/nanov_sequencer.sv | 102 ++++++++++
 tb/tb_nanov_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/nanov_pkg.sv
// Shared nanoV definitions: opcodes, special instruction words, sequencer states
// and the per-instruction step decode used by both the core and the sequencer.
package nanov_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [31:0] INSTR_NOP    = 32'h00000013;
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StHalt
  } state_e;

  // Memory and control-flow instructions need a second 32-clock pass.
  function automatic logic [2:0] nsteps(input logic [6:0] opcode);
    case (opcode)
      OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: nsteps = 3'd2;
      default:                                       nsteps = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/nanov_sequencer_if.sv
// Instruction fetch handshake between the sequencer (master) and instruction memory.
interface nanov_sequencer_if #(
  parameter int unsigned ADDR_W = 24
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_rdata
  );
endinterface

// File: rtl/nanov_sequencer.sv
// nanoV instruction sequencer: owns the PC, fetches one word at a time, steps the
// bit-serial counter/cycle during EXEC, applies branches at instruction end, halts on EBREAK.
module nanov_sequencer
  import nanov_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                clk,
  input  logic                rstn,
  nanov_sequencer_if.master   mem,
  output logic [31:0]         instr_o,
  output logic [4:0]          counter_o,
  output logic [2:0]          cycle_o,
  output logic                core_en_o,
  input  logic                branch_i,
  input  logic [ADDR_W-1:0]   target_i,
  input  logic                resume_i,
  output logic                halted_o,
  output logic [ADDR_W-1:0]   pc_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [4:0]        counter_q, counter_d;
  logic [2:0]        cycle_q, cycle_d;
  logic              mem_req_q, mem_req_d;
  logic [2:0]        last_step;
  logic              unused_target;

  assign last_step     = nsteps(instr_q[6:0]) - 3'd1;
  assign unused_target = ^target_i[1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StFetch;
      pc_q      <= RESET_ADDR;
      instr_q   <= INSTR_NOP;
      counter_q <= '0;
      cycle_q   <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      counter_q <= counter_d;
      cycle_q   <= cycle_d;
      mem_req_q <= mem_req_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    counter_d = counter_q;
    cycle_d   = cycle_q;
    unique case (state_q)
      StFetch: begin
        if (mem_req_q && mem.mem_valid) begin
          instr_d = mem.mem_rdata;
          state_d = (mem.mem_rdata == INSTR_EBREAK) ? StHalt : StExec;
        end
      end
      StExec: begin
        counter_d = counter_q + 5'd1;
        if (counter_q == 5'd31) begin
          if (cycle_q == last_step) begin
            cycle_d = '0;
            state_d = StFetch;
            pc_d    = branch_i ? {target_i[ADDR_W-1:2], 2'b00} : pc_q + ADDR_W'(4);
          end else begin
            cycle_d = cycle_q + 3'd1;
          end
        end
      end
      StHalt: begin
        if (resume_i) begin
          pc_d    = pc_q + ADDR_W'(4);
          state_d = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
    // Request follows the state, so the handshake clock always drops it for at least one clock.
    mem_req_d = (state_d == StFetch);
  end

  always_comb begin
    core_en_o = (state_q == StExec);
    halted_o  = (state_q == StHalt);
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc_q;
  assign instr_o      = instr_q;
  assign counter_o    = counter_q;
  assign cycle_o      = cycle_q;
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_nanov_sequencer.sv
// Directed bench for nanov_sequencer: fetch/exec timing, multi-step ops, branches,
// EBREAK halt/resume, PC wrap and synchronous reset mid-instruction.
module tb_nanov_sequencer;

  logic        clk = 1'b0;
  logic        rstn, rstn1;
  logic        branch, resume;
  logic [23:0] target;

  logic [31:0] instr0, instr1;
  logic [4:0]  counter, counter1;
  logic [2:0]  cycle, cycle1;
  logic        core_en, core_en1, halted, halted1;
  logic [23:0] pc0, pc1;

  int checks = 0;
  int errors = 0;

  nanov_sequencer_if #(.ADDR_W(24)) mif0 ();
  nanov_sequencer_if #(.ADDR_W(24)) mif1 ();

  nanov_sequencer #(.ADDR_W(24), .RESET_ADDR(24'h000000)) dut0 (
    .clk(clk), .rstn(rstn), .mem(mif0), .instr_o(instr0), .counter_o(counter),
    .cycle_o(cycle), .core_en_o(core_en), .branch_i(branch), .target_i(target),
    .resume_i(resume), .halted_o(halted), .pc_o(pc0)
  );

  nanov_sequencer #(.ADDR_W(24), .RESET_ADDR(24'hFFFFFC)) dut1 (
    .clk(clk), .rstn(rstn1), .mem(mif1), .instr_o(instr1), .counter_o(counter1),
    .cycle_o(cycle1), .core_en_o(core_en1), .branch_i(branch), .target_i(target),
    .resume_i(resume), .halted_o(halted1), .pc_o(pc1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits `hold` clocks with mem_valid low, then completes one fetch of word w on dut0.
  task automatic fetch0(input logic [31:0] w, input int hold, output logic bad);
    logic [23:0] a;
    bad = (mif0.mem_req !== 1'b1);
    a   = mif0.mem_addr;
    repeat (hold) begin
      step(1);
      if (mif0.mem_req !== 1'b1 || mif0.mem_addr !== a) bad = 1'b1;
    end
    mif0.mem_valid = 1'b1;
    mif0.mem_rdata = w;
    step(1);
    mif0.mem_valid = 1'b0;
    mif0.mem_rdata = '0;
  endtask

  // Counts EXEC clocks on dut0, checking counter/cycle progression; drives branch/resume
  // only at the chosen clock index.
  task automatic run_exec(input int br_at, input logic [23:0] tgt, input int rs_at,
                          input int stop_at, output int n, output logic bad);
    n   = 0;
    bad = 1'b0;
    while (core_en === 1'b1 && n < stop_at) begin
      if (counter !== 5'(n % 32) || cycle !== 3'(n / 32)) bad = 1'b1;
      branch = (n == br_at);
      target = tgt;
      resume = (n == rs_at);
      step(1);
      n++;
    end
    branch = 1'b0;
    resume = 1'b0;
    target = '0;
  endtask

  initial begin
    int   n;
    logic bad;
    logic [23:0] a;

    rstn = 1'b0; rstn1 = 1'b0;
    branch = 1'b0; resume = 1'b0; target = '0;
    mif0.mem_valid = 1'b0; mif0.mem_rdata = '0;
    mif1.mem_valid = 1'b0; mif1.mem_rdata = '0;
    step(2);

    check("rst_mem_req", 32'(mif0.mem_req), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", 32'(pc0), 32'h0);
    check("rst_instr", instr0, 32'h00000013);
    check("rst_cnt_cyc", {24'd0, counter, cycle}, 32'd0);

    // NOP at 0; a resume pulse mid-EXEC must be ignored.
    rstn = 1'b1;
    step(1);
    check("first_req", 32'(mif0.mem_req), 32'd1);
    check("first_addr", 32'(mif0.mem_addr), 32'h0);
    fetch0(32'h00000013, 0, bad);
    check("nop_fetch_ok", 32'(bad), 32'd0);
    check("nop_core_en", 32'(core_en), 32'd1);
    check("nop_req_drop", 32'(mif0.mem_req), 32'd0);
    run_exec(-1, 24'h0, 5, 200, n, bad);
    check("nop_len", 32'(n), 32'd32);
    check("nop_seq", 32'(bad), 32'd0);
    check("nop_next_req", 32'(mif0.mem_req), 32'd1);
    check("nop_next_addr", 32'(mif0.mem_addr), 32'h4);

    // LW at 4: two steps.
    fetch0(32'h00002083, 0, bad);
    check("lw_instr", instr0, 32'h00002083);
    run_exec(-1, 24'h0, -1, 200, n, bad);
    check("lw_len", 32'(n), 32'd64);
    check("lw_seq", 32'(bad), 32'd0);
    check("lw_next_addr", 32'(mif0.mem_addr), 32'h8);

    // BEQ at 8, taken at the final clock; target low bits dropped.
    fetch0(32'h00000063, 0, bad);
    run_exec(63, 24'h000123, -1, 200, n, bad);
    check("br_len", 32'(n), 32'd64);
    check("br_taken_addr", 32'(mif0.mem_addr), 32'h120);

    // BEQ at 0x120 with branch only at counter 10: not taken.
    fetch0(32'h00000063, 0, bad);
    run_exec(10, 24'h000123, -1, 200, n, bad);
    check("br_ignored_addr", 32'(mif0.mem_addr), 32'h124);

    // JAL at 0x124 jumping to 8.
    fetch0(32'h0000006F, 0, bad);
    run_exec(63, 24'h000008, -1, 200, n, bad);
    check("jal_addr", 32'(mif0.mem_addr), 32'h8);

    // EBREAK at 8: halt; stray mem_valid must not change instr.
    fetch0(32'h00100073, 0, bad);
    check("ebreak_halted", 32'(halted), 32'd1);
    check("ebreak_pc", 32'(pc0), 32'h8);
    bad = 1'b0;
    mif0.mem_valid = 1'b1;
    mif0.mem_rdata = 32'h00000013;
    repeat (20) begin
      step(1);
      if (mif0.mem_req !== 1'b0 || core_en !== 1'b0 || halted !== 1'b1 ||
          counter !== 5'd0 || cycle !== 3'd0) bad = 1'b1;
    end
    mif0.mem_valid = 1'b0;
    check("halt_hold", 32'(bad), 32'd0);
    check("halt_instr", instr0, 32'h00100073);
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    check("resume_halted", 32'(halted), 32'd0);
    check("resume_req", 32'(mif0.mem_req), 32'd1);
    check("resume_addr", 32'(mif0.mem_addr), 32'hC);

    // LW at 12 with reset at counter 17 of cycle 1.
    fetch0(32'h00002083, 2, bad);
    check("wait_stable", 32'(bad), 32'd0);
    run_exec(-1, 24'h0, -1, 49, n, bad);
    check("pre_rst_pos", {24'd0, counter, cycle}, {24'd0, 5'd17, 3'd1});
    rstn = 1'b0;
    step(1);
    check("mid_rst_cnt_cyc", {24'd0, counter, cycle}, 32'd0);
    check("mid_rst_core_en", 32'(core_en), 32'd0);
    check("mid_rst_instr", instr0, 32'h00000013);
    check("mid_rst_pc", 32'(pc0), 32'h0);
    rstn = 1'b1;
    step(1);
    check("post_rst_req", 32'(mif0.mem_req), 32'd1);

    // Second instance: reset at 0xFFFFFC, fetch held off 5 clocks, PC wraps to 0.
    rstn1 = 1'b1;
    step(1);
    check("wrap_first_addr", 32'(mif1.mem_addr), 32'hFFFFFC);
    bad = 1'b0;
    a   = mif1.mem_addr;
    repeat (5) begin
      step(1);
      if (mif1.mem_req !== 1'b1 || mif1.mem_addr !== a) bad = 1'b1;
    end
    check("wrap_hold_stable", 32'(bad), 32'd0);
    mif1.mem_valid = 1'b1;
    mif1.mem_rdata = 32'h00000013;
    step(1);
    mif1.mem_valid = 1'b0;
    n = 0;
    while (core_en1 === 1'b1 && n < 200) begin
      step(1);
      n++;
    end
    check("wrap_len", 32'(n), 32'd32);
    check("wrap_req", 32'(mif1.mem_req), 32'd1);
    check("wrap_addr", 32'(mif1.mem_addr), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
